// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode 7-segment display.
// Holds a multi-digit BCD value and presents one nibble at a time to a shared
// decoder. It drives one-hot digit enables, with a blanking guard at the start
// of every digit slot.
module seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  lz_en,
  output logic [3:0]            dec_bcd,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_done,
  output logic                  load_err
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]     CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIG_ONE    = DIGITS'(1);

  typedef enum logic {BLANK, SHOW} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DIGITS-1:0][3:0]  pending_q, pending_d;
  logic [DIGITS-1:0][3:0]  active_q, active_d;
  logic [3:0]              dec_q, dec_d;
  logic [DIGITS-1:0]       dig_q, dig_d;
  logic                    fd_q, fd_d;
  logic                    le_q, le_d;
  logic                    load_ok;
  logic                    wrap;
  logic                    suppress;

  assign dec_bcd    = dec_q;
  assign dig_en     = dig_q;
  assign frame_done = fd_q;
  assign load_err   = le_q;

  // A load is accepted only when every nibble is a legal BCD digit.
  always_comb begin
    load_ok = load;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (bcd_in[4*k +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // Current digit is blanked when it and every more-significant digit is zero.
  always_comb begin
    suppress = lz_en && (idx_q != '0);
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if ((j >= 32'(idx_q)) && (active_q[j[IW-1:0]] != 4'd0)) suppress = 1'b0;
    end
  end

  // State, counters and value registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      pending_q <= '0;
      active_q  <= '0;
      dec_q     <= '0;
      dig_q     <= '0;
      fd_q      <= 1'b0;
      le_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      dec_q     <= dec_d;
      dig_q     <= dig_d;
      fd_q      <= fd_d;
      le_q      <= le_d;
    end
  end

  // Next-state: slot sequencing, digit advance, and the frame-wrap handoff.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    wrap      = 1'b0;
    pending_d = load_ok ? bcd_in : pending_q;
    active_d  = active_q;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) state_d = SHOW;
      end
      SHOW: begin
        if (cnt_q == CNT_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
            // A valid load landing on the wrap cycle bypasses pending.
            active_d = load_ok ? bcd_in : pending_q;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // Outputs: computed from next-state values so that every port is a flop.
  always_comb begin
    dec_d = active_d[idx_d];
    fd_d  = wrap;
    le_d  = load && !load_ok;
    dig_d = '0;
    if (state_q == BLANK && state_d == SHOW) begin
      dig_d = suppress ? '0 : (DIG_ONE << idx_q);
    end else if (state_q == SHOW && state_d == SHOW) begin
      dig_d = dig_q;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int RD     = 8;
  localparam int BC     = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] bcd_in;
  logic        lz_en;
  logic [3:0]  dec_bcd;
  logic [3:0]  dig_en;
  logic        frame_done;
  logic        load_err;

  int n_chk = 0;
  int n_err = 0;

  seg_scan_ctrl #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .bcd_in    (bcd_in),
    .lz_en     (lz_en),
    .dec_bcd   (dec_bcd),
    .dig_en    (dig_en),
    .frame_done(frame_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks one full 32-cycle frame starting at its cycle 0, checking every cycle.
  // val/mask are the hand-computed displayed value and enabled-digit mask.
  task automatic check_frame(input string tag, input logic [15:0] val,
                             input logic [3:0] mask, input logic fd_first,
                             input int ld_c, input logic [15:0] ld_v,
                             input int ld_c2, input logic [15:0] ld_v2,
                             input int le_c);
    int s;
    int k;
    logic [3:0] e_dec;
    logic [3:0] e_dig;
    for (int c = 0; c < 32; c++) begin
      s     = c / RD;
      k     = c % RD;
      e_dec = val[4*s +: 4];
      e_dig = (k >= BC && mask[s]) ? 4'(1 << s) : 4'd0;
      chk($sformatf("%s dec_bcd c%0d", tag, c), 32'(dec_bcd), 32'(e_dec));
      chk($sformatf("%s dig_en c%0d", tag, c), 32'(dig_en), 32'(e_dig));
      chk($sformatf("%s frame_done c%0d", tag, c), 32'(frame_done),
          (c == 0) ? 32'(fd_first) : 32'd0);
      chk($sformatf("%s load_err c%0d", tag, c), 32'(load_err), (c == le_c) ? 32'd1 : 32'd0);
      load   = (c == ld_c) || (c == ld_c2);
      bcd_in = (c == ld_c2) ? ld_v2 : ld_v;
      step();
    end
    load = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    bcd_in = '0;
    lz_en  = 1'b0;
    step();
    step();
    chk("reset dec_bcd", 32'(dec_bcd), 32'd0);
    chk("reset dig_en", 32'(dig_en), 32'd0);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    chk("reset load_err", 32'(load_err), 32'd0);
    rst_n = 1'b1;

    // Basic scan: first frame shows the reset value, 1234 loaded mid-frame.
    check_frame("f0", 16'h0000, 4'b1111, 1'b0, 5, 16'h1234, -1, 16'h0, -1);
    check_frame("f1", 16'h1234, 4'b1111, 1'b1, -1, 16'h0, -1, 16'h0, -1);
    // Invalid load is rejected with a one-cycle error pulse.
    check_frame("f2", 16'h1234, 4'b1111, 1'b1, 3, 16'h12A4, -1, 16'h0, 4);
    // Leading-zero suppression.
    lz_en = 1'b1;
    check_frame("f3", 16'h1234, 4'b1111, 1'b1, 10, 16'h0050, -1, 16'h0, -1);
    check_frame("f4", 16'h0050, 4'b0011, 1'b1, 20, 16'h0000, -1, 16'h0, -1);
    // Load in the wrap cycle bypasses straight into the new frame.
    check_frame("f5", 16'h0000, 4'b0001, 1'b1, 31, 16'h5678, -1, 16'h0, -1);
    // Load just after frame_done waits a full frame.
    check_frame("f6", 16'h5678, 4'b1111, 1'b1, 1, 16'h9999, -1, 16'h0, -1);
    // Two loads in one frame: the last wins.
    check_frame("f7", 16'h9999, 4'b1111, 1'b1, 4, 16'h1111, 20, 16'h2222, -1);
    check_frame("f8", 16'h2222, 4'b1111, 1'b1, -1, 16'h0, -1, 16'h0, -1);

    // Reset during the digit-2 SHOW, with a competing load that must be ignored.
    for (int c = 0; c < 19; c++) begin
      if (c == 0)  chk("f9 frame_done c0", 32'(frame_done), 32'd1);
      if (c == 18) begin
        chk("f9 dig_en c18", 32'(dig_en), 32'b0100);
        chk("f9 dec_bcd c18", 32'(dec_bcd), 32'd2);
      end
      step();
    end
    rst_n  = 1'b0;
    load   = 1'b1;
    bcd_in = 16'h4321;
    step();
    rst_n = 1'b1;
    load  = 1'b0;
    chk("midrst dec_bcd", 32'(dec_bcd), 32'd0);
    chk("midrst dig_en", 32'(dig_en), 32'd0);
    chk("midrst frame_done", 32'(frame_done), 32'd0);
    chk("midrst load_err", 32'(load_err), 32'd0);
    check_frame("f10", 16'h0000, 4'b0001, 1'b0, -1, 16'h0, -1, 16'h0, -1);
    check_frame("f11", 16'h0000, 4'b0001, 1'b1, -1, 16'h0, -1, 16'h0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
